// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter: merges ALU results and load responses into one registered
// register-file write stream, with a pending-load scoreboard. Optional forwarding: RISCV_WB_BYPASS_EN.
module riscv_wb_arbiter #(
  parameter int WORD_LENGTH  = 32,
  parameter int ADDR_LENGTH  = 5,
  parameter int NUM_REGS     = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [ADDR_LENGTH-1:0] alu_rd,
  input  logic [WORD_LENGTH-1:0] alu_data,
  output logic                   alu_stall,
  input  logic                   issue_valid,
  input  logic [ADDR_LENGTH-1:0] issue_rd,
  input  logic                   mem_valid,
  input  logic [ADDR_LENGTH-1:0] mem_rd,
  input  logic [WORD_LENGTH-1:0] mem_data,
  output logic                   mem_ready,
  input  logic [ADDR_LENGTH-1:0] rs_addr1,
  input  logic [ADDR_LENGTH-1:0] rs_addr2,
  output logic                   busy1,
  output logic                   busy2,
  output logic                   fwd_valid1,
  output logic                   fwd_valid2,
  output logic [WORD_LENGTH-1:0] fwd_data1,
  output logic [WORD_LENGTH-1:0] fwd_data2,
  output logic                   wb_en,
  output logic [ADDR_LENGTH-1:0] wb_addr,
  output logic [WORD_LENGTH-1:0] wb_data
);

  typedef enum logic [1:0] {S_EMPTY, S_HELD, S_FORCE} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_LENGTH-1:0] buf_rd_q, buf_rd_d;
  logic [WORD_LENGTH-1:0] buf_data_q, buf_data_d;
  logic                   wb_en_q, wb_en_d;
  logic [ADDR_LENGTH-1:0] wb_addr_q, wb_addr_d;
  logic [WORD_LENGTH-1:0] wb_data_q, wb_data_d;
  logic                   wb_load_q, wb_load_d;
  logic [NUM_REGS-1:0]    pending_q, pending_d;

  logic                   wr_valid;
  logic                   wr_load;
  logic [ADDR_LENGTH-1:0] wr_rd;
  logic [WORD_LENGTH-1:0] wr_data;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    alu_stall  = 1'b0;
    mem_ready  = (state_q == S_EMPTY);
    wr_valid   = 1'b0;
    wr_load    = 1'b0;
    wr_rd      = '0;
    wr_data    = '0;
    case (state_q)
      S_EMPTY: begin
        if (alu_valid) begin
          wr_valid = 1'b1;
          wr_rd    = alu_rd;
          wr_data  = alu_data;
          if (mem_valid) begin
            buf_rd_d   = mem_rd;
            buf_data_d = mem_data;
            cnt_d      = '0;
            state_d    = S_HELD;
          end
        end else if (mem_valid) begin
          wr_valid = 1'b1;
          wr_load  = 1'b1;
          wr_rd    = mem_rd;
          wr_data  = mem_data;
        end
      end
      S_HELD: begin
        if (alu_valid) begin
          wr_valid = 1'b1;
          wr_rd    = alu_rd;
          wr_data  = alu_data;
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == LIMIT) state_d = S_FORCE;
        end else begin
          wr_valid = 1'b1;
          wr_load  = 1'b1;
          wr_rd    = buf_rd_q;
          wr_data  = buf_data_q;
          state_d  = S_EMPTY;
        end
      end
      S_FORCE: begin
        alu_stall = 1'b1;
        wr_valid  = 1'b1;
        wr_load   = 1'b1;
        wr_rd     = buf_rd_q;
        wr_data   = buf_data_q;
        state_d   = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase

    // x0 writes complete their handshake but never reach the register file
    wb_en_d   = wr_valid && (wr_rd != '0);
    wb_load_d = wr_load && wb_en_d;
    wb_addr_d = wb_en_d ? wr_rd : wb_addr_q;
    wb_data_d = wb_en_d ? wr_data : wb_data_q;

    pending_d = pending_q;
    if (wb_en_q && wb_load_q) pending_d[wb_addr_q] = 1'b0;
    if (issue_valid && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
`ifdef RISCV_WB_BYPASS_EN
    fwd_valid1 = wb_en_q && (wb_addr_q == rs_addr1) && (rs_addr1 != '0);
    fwd_valid2 = wb_en_q && (wb_addr_q == rs_addr2) && (rs_addr2 != '0);
    fwd_data1  = fwd_valid1 ? wb_data_q : '0;
    fwd_data2  = fwd_valid2 ? wb_data_q : '0;
    busy1      = pending_q[rs_addr1] && !fwd_valid1;
    busy2      = pending_q[rs_addr2] && !fwd_valid2;
`else
    fwd_valid1 = 1'b0;
    fwd_valid2 = 1'b0;
    fwd_data1  = '0;
    fwd_data2  = '0;
    busy1      = pending_q[rs_addr1];
    busy2      = pending_q[rs_addr2];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      cnt_q      <= '0;
      buf_rd_q   <= '0;
      buf_data_q <= '0;
      wb_en_q    <= 1'b0;
      wb_load_q  <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      pending_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      wb_en_q    <= wb_en_d;
      wb_load_q  <= wb_load_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      pending_q  <= pending_d;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

endmodule

// File: doc/riscv_wb_arbiter.md
# riscv_wb_arbiter

Writeback arbiter sitting in front of the register file's single write port (write_en/write_addr/data). It merges single-cycle ALU results and multi-cycle load responses into one registered write stream and holds a pending-load scoreboard that tells decode when a source register is still awaiting load data. It is the writer-side counterpart of the register file.

## Interface
- WORD_LENGTH, 32, data width
- ADDR_LENGTH, 5, register address width
- NUM_REGS, 32, register count; scoreboard depth
- STARVE_LIMIT, 3, cycles a buffered load may lose to the ALU before the ALU is stalled (1..15)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result present
- alu_rd  in  ADDR_LENGTH  ALU destination
- alu_data  in  WORD_LENGTH  ALU result
- alu_stall  out  1  ALU result not accepted; upstream holds alu_* stable
- issue_valid  in  1  load issued this cycle
- issue_rd  in  ADDR_LENGTH  load destination
- mem_valid  in  1  load response present
- mem_rd  in  ADDR_LENGTH  response destination
- mem_data  in  WORD_LENGTH  response data
- mem_ready  out  1  response accepted when mem_valid & mem_ready
- rs_addr1, rs_addr2  in  ADDR_LENGTH  decode source lookups
- busy1, busy2  out  1  source awaits load data
- fwd_valid1, fwd_valid2  out  1  forward data valid for source
- fwd_data1, fwd_data2  out  WORD_LENGTH  forward data
- wb_en  out  1  to register file write_en
- wb_addr  out  ADDR_LENGTH  to write_addr
- wb_data  out  WORD_LENGTH  to data

## Operation
- One-entry load buffer; mem_ready = buffer empty (combinational from state).
- States: EMPTY (buffer empty), HELD (buffer full, starve counter counting), FORCE (buffer full, counter == STARVE_LIMIT).
- EMPTY: ALU valid → write ALU; concurrent accepted load → buffer, go HELD, counter=0. No ALU, load accepted → write load directly, stay EMPTY.
- HELD: no ALU → write buffer, go EMPTY. ALU valid → write ALU, counter+1; reaching STARVE_LIMIT → FORCE.
- FORCE: alu_stall=1, write buffer, go EMPTY; ALU result taken next cycle.
- alu_stall is 0 in EMPTY/HELD.
- Writes to x0 (rd==0) are dropped: wb_en stays 0, but the handshake still completes.
- Scoreboard pending[NUM_REGS]: set by issue_valid on issue_rd (rd≠0); cleared on the edge after a load write is presented (wb_en & load-sourced). Simultaneous set and clear on the same rd: set wins. pending[0] is always 0.
- busyN = pending[rs_addrN], subject to bypass (see Configuration).
- Issuing to an already-pending rd is illegal; the bench asserts this never happens.

## Timing
- wb_en/wb_addr/wb_data are registered: the result is visible the cycle after acceptance, and the register file updates at the following edge.
- Latency from acceptance to register file update: 2 edges.
- Reset (async): state EMPTY, counter 0, pending all 0, wb_en 0, wb_addr 0, wb_data 0, alu_stall 0, fwd_valid 0.
- Reset mid-operation discards any buffered load. The memory side must reissue after reset.
- Outputs other than wb_* are combinational from state and inputs.

## Configuration
- RISCV_WB_BYPASS_EN defined: while wb_en=1 and wb_addr==rs_addrN≠0, fwd_validN=1, fwd_dataN=wb_data, and busyN is forced 0.
- Undefined: fwd_valid1/2 and fwd_data1/2 are tied to 0. busyN stays 1 until pending clears, which costs one extra decode-stall cycle per load-use.

## Test plan
- ALU rd=5, data=0x11 at cycle 0, no load → wb_en=1, wb_addr=5, wb_data=0x11 at cycle 1; regfile[5]=0x11 after cycle 1's edge.
- Concurrent ALU (rd=3, 0xA) and load (rd=4, 0xB) → cycle 1 writes r3, cycle 2 writes r4, mem_ready=0 during cycle 1.
- Buffered load with ALU valid every cycle, STARVE_LIMIT=3 → 3 ALU writes, then alu_stall=1 for one cycle with the load written, then ALU resumes.
- Issue to rd=7, response 4 cycles later → busy1(rs=7)=1 until the clear edge. With bypass, fwd_valid1=1 and busy1=0 in the wb cycle. Without bypass, busy1 stays 1 that cycle.
- ALU and load responses with rd=0 → wb_en stays 0, mem_ready handshake completes, pending[0]=0.
- Assert rst while buffer is HELD → mem_ready=1, all pending=0, and wb_en=0 immediately, before the next clock edge.
